// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencing FSM: fetch/decode/execute/memory/write-back with mem_ready stalls.
// Optional bne support is enabled by defining MULTICYCLE_BNE_EN.
module multicycle_control (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        BranchNe,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        IRWrite,
    output logic [1:0]  PCSource,
    output logic [1:0]  ALUOp,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic        RegWrite,
    output logic        RegDst,
    output logic [3:0]  State,
    output logic        IllegalOp,
    output logic        InstrDone,
    output logic [31:0] InstrCount
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_IMMEX  = 4'd11,
        S_IMMWB  = 4'd12,
        S_TRAP   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;

`ifdef MULTICYCLE_BNE_EN
    localparam logic BNE_EN = 1'b1;
`else
    localparam logic BNE_EN = 1'b0;
`endif

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_count;

    assign State      = r_state;
    assign InstrCount = r_count;

    always_comb begin
        w_next      = S_FETCH;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNe    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        PCSource    = 2'b00;
        ALUOp       = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        IllegalOp   = 1'b0;
        InstrDone   = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                w_next  = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Branch target is precomputed here while the opcode is decoded.
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_RTYPE:          w_next = S_EXEC;
                    OP_LW, OP_SW:      w_next = S_MEMADR;
                    OP_BEQ:            w_next = S_BRANCH;
                    OP_BNE:            w_next = BNE_EN ? S_BRANCH : S_TRAP;
                    OP_J:              w_next = S_JUMP;
                    OP_ADDI, OP_ADDIU: w_next = S_IMMEX;
                    default:           w_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_next  = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                w_next  = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                MemtoReg  = 1'b1;
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            S_MEMWR: begin
                MemWrite  = 1'b1;
                IorD      = 1'b1;
                InstrDone = mem_ready;
                w_next    = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                w_next  = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst    = 1'b1;
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                BranchNe    = BNE_EN && (opcode == OP_BNE);
                InstrDone   = 1'b1;
            end
            S_JUMP: begin
                PCWrite   = 1'b1;
                PCSource  = 2'b10;
                InstrDone = 1'b1;
            end
            S_IMMEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_next  = S_IMMWB;
            end
            S_IMMWB: begin
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            S_TRAP: IllegalOp = 1'b1;
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_count <= 32'd0;
        end else begin
            r_state <= w_next;
            if (InstrDone)
                r_count <= r_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: stimulus pushes expected per-cycle outputs, a monitor pops and checks.
module tb_multicycle_control;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
    logic [1:0]  PCSource, ALUOp, ALUSrcB;
    logic        ALUSrcA, RegWrite, RegDst, IllegalOp, InstrDone;
    logic [3:0]  State;
    logic [31:0] InstrCount;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite),
        .PCSource(PCSource), .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .RegWrite(RegWrite), .RegDst(RegDst), .State(State), .IllegalOp(IllegalOp),
        .InstrDone(InstrDone), .InstrCount(InstrCount)
    );

    always #5 clk = ~clk;

    // Control vector bit positions, MSB first in the order of the port list.
    localparam logic [18:0] B_PCW   = 19'h40000;
    localparam logic [18:0] B_PCWC  = 19'h20000;
    localparam logic [18:0] B_BNE   = 19'h10000;
    localparam logic [18:0] B_IORD  = 19'h08000;
    localparam logic [18:0] B_MRD   = 19'h04000;
    localparam logic [18:0] B_MWR   = 19'h02000;
    localparam logic [18:0] B_M2R   = 19'h01000;
    localparam logic [18:0] B_IRW   = 19'h00800;
    localparam logic [18:0] B_PS01  = 19'h00200;
    localparam logic [18:0] B_PS10  = 19'h00400;
    localparam logic [18:0] B_OP01  = 19'h00080;
    localparam logic [18:0] B_OP10  = 19'h00100;
    localparam logic [18:0] B_SRCA  = 19'h00040;
    localparam logic [18:0] B_SB01  = 19'h00010;
    localparam logic [18:0] B_SB10  = 19'h00020;
    localparam logic [18:0] B_SB11  = 19'h00030;
    localparam logic [18:0] B_RW    = 19'h00008;
    localparam logic [18:0] B_RDST  = 19'h00004;
    localparam logic [18:0] B_ILL   = 19'h00002;
    localparam logic [18:0] B_DONE  = 19'h00001;

    localparam logic [18:0] C_NONE     = 19'h0;
    localparam logic [18:0] C_FETCH_W  = B_MRD | B_SB01;
    localparam logic [18:0] C_FETCH    = B_MRD | B_SB01 | B_IRW | B_PCW;
    localparam logic [18:0] C_DECODE   = B_SB11;
    localparam logic [18:0] C_MEMADR   = B_SRCA | B_SB10;
    localparam logic [18:0] C_MEMRD    = B_MRD | B_IORD;
    localparam logic [18:0] C_MEMWB    = B_M2R | B_RW | B_DONE;
    localparam logic [18:0] C_MEMWR_W  = B_MWR | B_IORD;
    localparam logic [18:0] C_MEMWR    = B_MWR | B_IORD | B_DONE;
    localparam logic [18:0] C_EXEC     = B_SRCA | B_OP10;
    localparam logic [18:0] C_ALUWB    = B_RDST | B_RW | B_DONE;
    localparam logic [18:0] C_BRANCH   = B_SRCA | B_OP01 | B_PCWC | B_PS01 | B_DONE;
    localparam logic [18:0] C_JUMP     = B_PCW | B_PS10 | B_DONE;
    localparam logic [18:0] C_IMMEX    = B_SRCA | B_SB10;
    localparam logic [18:0] C_IMMWB    = B_RW | B_DONE;
    localparam logic [18:0] C_TRAP     = B_ILL;

    wire [18:0] act_ctrl = {PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, MemtoReg,
                            IRWrite, PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst,
                            IllegalOp, InstrDone};

    logic [54:0] exp_q[$];
    logic [54:0] mon_e;
    logic [31:0] exp_cnt = 32'd0;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;

    // One cycle: drive inputs just after the edge, queue what this cycle must show, advance.
    task automatic step(input logic rst, input logic [5:0] op, input logic mr,
                        input logic chk, input logic [3:0] es, input logic [18:0] ec);
        rst_n = rst;
        opcode = op;
        mem_ready = mr;
        if (chk) exp_q.push_back({es, ec, exp_cnt});
        @(posedge clk);
        #1;
        if (!rst) exp_cnt = 32'd0;
        else if (chk && ec[0]) exp_cnt = exp_cnt + 32'd1;
    endtask

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks = checks + 3;
            $display("cyc %0d: state=%0d ctrl=%05h count=%0d (want state=%0d ctrl=%05h count=%0d)",
                     cyc, State, act_ctrl, InstrCount, mon_e[54:51], mon_e[50:32], mon_e[31:0]);
            if (State !== mon_e[54:51]) begin
                errors = errors + 1;
                $display("FAIL state: got %0d expected %0d", State, mon_e[54:51]);
            end
            if (act_ctrl !== mon_e[50:32]) begin
                errors = errors + 1;
                $display("FAIL ctrl (state %0d): got %05h expected %05h", State, act_ctrl, mon_e[50:32]);
            end
            if (InstrCount !== mon_e[31:0]) begin
                errors = errors + 1;
                $display("FAIL count: got %0d expected %0d", InstrCount, mon_e[31:0]);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        opcode = 6'd0;
        mem_ready = 1'b0;
        // Reset held for two edges, then IDLE and a stalled FETCH.
        step(1'b0, 6'd0, 1'b0, 1'b0, 4'd0, C_NONE);
        step(1'b0, 6'd0, 1'b0, 1'b0, 4'd0, C_NONE);
        step(1'b1, 6'd0, 1'b1, 1'b1, 4'd0, C_NONE);
        step(1'b1, 6'b100011, 1'b0, 1'b1, 4'd1, C_FETCH_W);
        // lw with two wait states in MEMRD
        step(1'b1, 6'b100011, 1'b1, 1'b1, 4'd1, C_FETCH);
        step(1'b1, 6'b100011, 1'b0, 1'b1, 4'd2, C_DECODE);
        step(1'b1, 6'b100011, 1'b0, 1'b1, 4'd3, C_MEMADR);
        step(1'b1, 6'b100011, 1'b0, 1'b1, 4'd4, C_MEMRD);
        step(1'b1, 6'b100011, 1'b0, 1'b1, 4'd4, C_MEMRD);
        step(1'b1, 6'b100011, 1'b1, 1'b1, 4'd4, C_MEMRD);
        step(1'b1, 6'b100011, 1'b0, 1'b1, 4'd5, C_MEMWB);
        // R-type (mem_ready low outside memory states must be ignored)
        step(1'b1, 6'b000000, 1'b1, 1'b1, 4'd1, C_FETCH);
        step(1'b1, 6'b000000, 1'b0, 1'b1, 4'd2, C_DECODE);
        step(1'b1, 6'b000000, 1'b0, 1'b1, 4'd7, C_EXEC);
        step(1'b1, 6'b000000, 1'b0, 1'b1, 4'd8, C_ALUWB);
        // sw, zero wait
        step(1'b1, 6'b101011, 1'b1, 1'b1, 4'd1, C_FETCH);
        step(1'b1, 6'b101011, 1'b1, 1'b1, 4'd2, C_DECODE);
        step(1'b1, 6'b101011, 1'b1, 1'b1, 4'd3, C_MEMADR);
        step(1'b1, 6'b101011, 1'b1, 1'b1, 4'd6, C_MEMWR);
        // beq then j
        step(1'b1, 6'b000100, 1'b1, 1'b1, 4'd1, C_FETCH);
        step(1'b1, 6'b000100, 1'b1, 1'b1, 4'd2, C_DECODE);
        step(1'b1, 6'b000100, 1'b1, 1'b1, 4'd9, C_BRANCH);
        step(1'b1, 6'b000010, 1'b1, 1'b1, 4'd1, C_FETCH);
        step(1'b1, 6'b000010, 1'b1, 1'b1, 4'd2, C_DECODE);
        step(1'b1, 6'b000010, 1'b1, 1'b1, 4'd10, C_JUMP);
        // addi
        step(1'b1, 6'b001000, 1'b1, 1'b1, 4'd1, C_FETCH);
        step(1'b1, 6'b001000, 1'b1, 1'b1, 4'd2, C_DECODE);
        step(1'b1, 6'b001000, 1'b1, 1'b1, 4'd11, C_IMMEX);
        step(1'b1, 6'b001000, 1'b1, 1'b1, 4'd12, C_IMMWB);
        // unsupported opcode traps without retiring
        step(1'b1, 6'b001111, 1'b1, 1'b1, 4'd1, C_FETCH);
        step(1'b1, 6'b001111, 1'b1, 1'b1, 4'd2, C_DECODE);
        step(1'b1, 6'b001111, 1'b1, 1'b1, 4'd13, C_TRAP);
        // bne: branch when enabled, trap otherwise
        step(1'b1, 6'b000101, 1'b1, 1'b1, 4'd1, C_FETCH);
        step(1'b1, 6'b000101, 1'b1, 1'b1, 4'd2, C_DECODE);
`ifdef MULTICYCLE_BNE_EN
        step(1'b1, 6'b000101, 1'b1, 1'b1, 4'd9, C_BRANCH | B_BNE);
`else
        step(1'b1, 6'b000101, 1'b1, 1'b1, 4'd13, C_TRAP);
`endif
        // sw stalled in MEMWR, reset asserted mid-write
        step(1'b1, 6'b101011, 1'b1, 1'b1, 4'd1, C_FETCH);
        step(1'b1, 6'b101011, 1'b0, 1'b1, 4'd2, C_DECODE);
        step(1'b1, 6'b101011, 1'b0, 1'b1, 4'd3, C_MEMADR);
        step(1'b1, 6'b101011, 1'b0, 1'b1, 4'd6, C_MEMWR_W);
        step(1'b0, 6'b101011, 1'b0, 1'b1, 4'd6, C_MEMWR_W);
        step(1'b1, 6'b101011, 1'b0, 1'b1, 4'd0, C_NONE);
        step(1'b1, 6'b101011, 1'b1, 1'b1, 4'd1, C_FETCH);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors = errors + 1;
            checks = checks + 1;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
